// File: rtl/ifns_tx_packer_if.sv
// ---------------------------------------------------------------------------
// ifns_tx_packer_if
//  Bundles the word-stream input and the chunk-stream output of the IFNS
//  transmit packer.
//  Modports:
//    master : stream source / encoder side (drives din*, observes the rest)
//    slave  : the packer itself
//  Signals:
//    din, din_valid, din_last  input word, its valid, end-of-frame marker
//    din_ready                 packer can take din this cycle
//    dataout, dout_valid       chunk to the encoder and its strobe
//    dout_last, pad_bits       last-chunk flag and its zero-pad count
// ---------------------------------------------------------------------------
interface ifns_tx_packer_if #(
   parameter int DIN_W  = 32,
   parameter int DOUT_W = 15
);
   localparam int PAD_W = $clog2(DOUT_W + 1);

   logic [DIN_W-1:0]  din;
   logic              din_valid;
   logic              din_last;
   logic              din_ready;
   logic [DOUT_W-1:0] dataout;
   logic              dout_valid;
   logic              dout_last;
   logic [PAD_W-1:0]  pad_bits;

   modport master (
      output din, din_valid, din_last,
      input  din_ready, dataout, dout_valid, dout_last, pad_bits
   );

   modport slave (
      input  din, din_valid, din_last,
      output din_ready, dataout, dout_valid, dout_last, pad_bits
   );
endinterface

// File: rtl/ifns_tx_packer.sv
// ---------------------------------------------------------------------------
// ifns_tx_packer
//  Upstream feeder for the 21-wire IFNS encoder. Accepts DIN_W-bit words over
//  valid/ready, repacks them LSB-first into DOUT_W-bit chunks (one per clock),
//  and at frame end flushes the residue as a zero-padded, flagged chunk.
//  Ports:
//    clock  rising-edge clock
//    rst_n  asynchronous active-low reset
//    bus    ifns_tx_packer_if.slave (din/din_valid/din_last/din_ready in,
//           dataout/dout_valid/dout_last/pad_bits out, all outputs registered
//           except din_ready, which is combinational from state)
//  Configuration macro:
//    IFNS_PACK_HOLD_IDLE_EN  defined   -> dataout holds last chunk when idle
//                            undefined -> dataout is zero when idle
// ---------------------------------------------------------------------------
module ifns_tx_packer #(
   parameter int DIN_W  = 32,
   parameter int DOUT_W = 15
) (
   input  logic               clock,
   input  logic               rst_n,
   ifns_tx_packer_if.slave    bus
);
   localparam int ACC_W = DIN_W + DOUT_W - 1;
   localparam int CNT_W = $clog2(DIN_W + DOUT_W);
   localparam int PAD_W = $clog2(DOUT_W + 1);

   typedef enum logic {RUN, FLUSH} state_e;

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DOUT_W-1:0] dataout_q, dataout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              dout_last_q, dout_last_d;
   logic [PAD_W-1:0]  pad_bits_q, pad_bits_d;

   logic              din_ready;
   logic              accept;
   logic [DOUT_W-1:0] tail_mask;

   // Accept only while fewer than a chunk's worth of bits is held: this is
   // what makes accept and emit mutually exclusive in any cycle.
   assign din_ready = (state_q == RUN) && (cnt_q < CNT_W'(DOUT_W));
   assign accept    = bus.din_valid && din_ready;
   assign tail_mask = ~({DOUT_W{1'b1}} << cnt_q);

   // NOTE: every always_comb output gets a default first so no path leaves a
   // signal unassigned, which would infer a latch.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      pad_bits_d   = '0;
`ifdef IFNS_PACK_HOLD_IDLE_EN
      dataout_d    = dataout_q;
`else
      dataout_d    = '0;
`endif

      if (accept) begin
         // Fits: cnt_q < DOUT_W, so the shifted word stays inside ACC_W bits.
         acc_d = acc_q | (ACC_W'(bus.din) << cnt_q);
         cnt_d = cnt_q + CNT_W'(DIN_W);
         if (bus.din_last) state_d = FLUSH;
      end else if (cnt_q >= CNT_W'(DOUT_W)) begin
         dataout_d    = acc_q[DOUT_W-1:0];
         dout_valid_d = 1'b1;
         acc_d        = acc_q >> DOUT_W;
         cnt_d        = cnt_q - CNT_W'(DOUT_W);
         // A full chunk that empties the accumulator closes the frame.
         if ((state_q == FLUSH) && (cnt_d == '0)) begin
            dout_last_d = 1'b1;
            state_d     = RUN;
         end
      end else if (state_q == FLUSH) begin
         if (cnt_q != '0) begin
            dataout_d    = acc_q[DOUT_W-1:0] & tail_mask;
            dout_valid_d = 1'b1;
            dout_last_d  = 1'b1;
            pad_bits_d   = PAD_W'(DOUT_W) - PAD_W'(cnt_q);
         end
         acc_d   = '0;
         cnt_d   = '0;
         state_d = RUN;
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge values; the reset clears the whole accumulator so a frame
   // cut short by reset cannot leak stale bits into the next one.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         acc_q        <= '0;
         cnt_q        <= '0;
         dataout_q    <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         pad_bits_q   <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         dataout_q    <= dataout_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         pad_bits_q   <= pad_bits_d;
      end
   end

   assign bus.din_ready  = din_ready;
   assign bus.dataout    = dataout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.dout_last  = dout_last_q;
   assign bus.pad_bits   = pad_bits_q;

endmodule

// File: tb/tb_ifns_tx_packer.sv
// ---------------------------------------------------------------------------
// tb_ifns_tx_packer
//  Directed bench for ifns_tx_packer (DIN_W=32, DOUT_W=15). A bit-level
//  reference model pushes expected chunks onto a scoreboard as words are
//  handed over; every clock the outputs are compared against the scoreboard
//  head (valid cycles) or against the expected idle value (other cycles).
// ---------------------------------------------------------------------------
module tb_ifns_tx_packer;
   localparam int DIN_W  = 32;
   localparam int DOUT_W = 15;
   localparam int PAD_W  = $clog2(DOUT_W + 1);

   typedef struct packed {
      logic [DOUT_W-1:0] data;
      logic              last;
      logic [PAD_W-1:0]  pad;
   } chunk_t;

   logic clock = 1'b0;
   logic rst_n = 1'b0;

   ifns_tx_packer_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

   ifns_tx_packer #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   chunk_t            sb[$];
   bit                mbits[$];
   int                n_vec  = 0;
   int                n_err  = 0;
   int                n_pops = 0;
   logic [DOUT_W-1:0] exp_idle = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      chunk_t got, exp;
      got = {bus.dataout, bus.dout_last, bus.pad_bits};
      if (bus.dout_valid === 1'b1) begin
         check("unexpected_chunk", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            n_pops++;
            check("chunk", 32'(got), 32'(exp));
`ifdef IFNS_PACK_HOLD_IDLE_EN
            exp_idle = exp.data;
`endif
         end
      end else begin
         check("idle", 32'({bus.dout_valid, got}),
               32'({1'b0, exp_idle, 1'b0, PAD_W'(0)}));
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   // Reference model: LSB-first bit queue cut into DOUT_W-bit chunks.
   task automatic model_accept(input logic [DIN_W-1:0] w, input bit last, output int n);
      chunk_t c;
      int     k;
      n = 0;
      for (int i = 0; i < DIN_W; i++) mbits.push_back(w[i]);
      while (mbits.size() > DOUT_W || (mbits.size() == DOUT_W && !last)) begin
         c = '0;
         for (int j = 0; j < DOUT_W; j++) c.data[j] = mbits.pop_front();
         sb.push_back(c);
         n++;
      end
      if (last) begin
         k = mbits.size();
         c = '0;
         for (int j = 0; j < k; j++) c.data[j] = mbits.pop_front();
         c.last = 1'b1;
         c.pad  = PAD_W'(DOUT_W - k);
         sb.push_back(c);
         n++;
      end
   endtask

   // Presents a word, waits (bounded) for din_ready, then takes the accept
   // edge. din_valid is left high so back-to-back words keep it asserted.
   task automatic send_word(input logic [DIN_W-1:0] w, input bit last, input bit use_model,
                            output int waits, output int nchunks);
      bus.din       = w;
      bus.din_last  = last;
      bus.din_valid = 1'b1;
      waits   = 0;
      nchunks = 0;
      while (bus.din_ready !== 1'b1 && waits < 40) begin
         tick();
         waits++;
      end
      check("ready_timeout", 32'(bus.din_ready), 32'd1);
      if (use_model) model_accept(w, last, nchunks);
      tick();
   endtask

   // Runs out the current frame: din_ready must stay low until the last chunk
   // has appeared, and be high on the cycle that shows it.
   task automatic drain();
      bit done;
      done = 1'b0;
      bus.din_valid = 1'b0;
      bus.din_last  = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (sb.size() == 0) begin
            check("ready_after_last", 32'(bus.din_ready), 32'd1);
            done = 1'b1;
         end else begin
            check("ready_in_flush", 32'(bus.din_ready), 32'd0);
         end
      end
      check("drain_timeout", 32'(done), 32'd1);
   endtask

   task automatic do_reset();
      bus.din_valid = 1'b0;
      bus.din_last  = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      mbits.delete();
      exp_idle = '0;
      #1;
      check("reset_outputs",
            32'({bus.dout_valid, bus.dout_last, bus.pad_bits, bus.dataout}), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("ready_after_reset", 32'(bus.din_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            waits, n, prev_n, pops0;
      logic [31:0]   w;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.din_last  = 1'b0;

      // Power-on reset
      rst_n = 1'b0;
      #1;
      check("por_outputs",
            32'({bus.dout_valid, bus.dout_last, bus.pad_bits, bus.dataout}), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("por_ready", 32'(bus.din_ready), 32'd1);

      // Reset mid-stream: one chunk out, second chunk and residue discarded
      send_word(32'hCAFE_F00D, 1'b0, 1'b1, waits, n);
      bus.din_valid = 1'b0;
      tick();
      do_reset();
      tick();

      // Single word frame with known chunk values
      sb.push_back({15'h3EEF, 1'b0, PAD_W'(0)});
      sb.push_back({15'h3D5B, 1'b0, PAD_W'(0)});
      sb.push_back({15'h0003, 1'b1, PAD_W'(13)});
      send_word(32'hDEAD_BEEF, 1'b1, 1'b0, waits, n);
      check("single_ready_wait", 32'(waits), 32'd0);
      drain();

      // Fifteen back-to-back words, din_valid held high; last chunk is 15'h1234
      pops0  = n_pops;
      prev_n = 0;
      for (int k = 0; k < 15; k++) begin
         w = $urandom();
         if (k == 14) w[31:17] = 15'h1234;
         send_word(w, k == 14, 1'b1, waits, n);
         check("ready_pattern", 32'(waits), 32'(prev_n));
         prev_n = n;
      end
      drain();
      check("chunk_count", 32'(n_pops - pops0), 32'd32);

      // Idle after chunk 15'h1234
      tick();
`ifdef IFNS_PACK_HOLD_IDLE_EN
      check("idle_hold", 32'({bus.dout_valid, bus.dataout}), 32'({1'b0, 15'h1234}));
`else
      check("idle_hold", 32'({bus.dout_valid, bus.dataout}), 32'({1'b0, 15'h0000}));
`endif

      // Reset during FLUSH with 17 bits still held
      send_word(32'h1357_9BDF, 1'b1, 1'b1, waits, n);
      bus.din_valid = 1'b0;
      tick();
      check("flush_ready_low", 32'(bus.din_ready), 32'd0);
      do_reset();
      send_word(32'hA5A5_5A5B, 1'b1, 1'b1, waits, n);
      tick();
      check("bit0_alignment", 32'({bus.dout_valid, bus.dataout[0]}), 32'd3);
      drain();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
